// File: rtl/seq_mult_param_if.sv
// Handshake/operand bundle for seq_mult_param; the master drives operands, the slave returns the product.
// Define OVF_DETECT_EN to add the o_overflow flag.
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    logic             i_run;
    logic             i_clr_ld;
    logic             i_signed_mode;
    logic [WIDTH-1:0] i_din;
    logic [WIDTH-1:0] o_aval;
    logic [WIDTH-1:0] o_bval;
    logic             o_x;
    logic             o_busy;
    logic             o_done;
`ifdef OVF_DETECT_EN
    logic             o_overflow;
`endif

    modport master (
`ifdef OVF_DETECT_EN
        input  o_overflow,
`endif
        output i_run, i_clr_ld, i_signed_mode, i_din,
        input  o_aval, o_bval, o_x, o_busy, o_done
    );

    modport slave (
`ifdef OVF_DETECT_EN
        output o_overflow,
`endif
        input  i_run, i_clr_ld, i_signed_mode, i_din,
        output o_aval, o_bval, o_x, o_busy, o_done
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, one iteration per clock, signed/unsigned, product {Aval,Bval}.
// Latency WIDTH cycles after the start edge; optional OVF_DETECT_EN adds a registered overflow flag.
module seq_mult_param #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    seq_mult_param_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_x;
    logic             r_mode;

    logic             w_last;
    logic             w_load;
    logic             w_start;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_acc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_x_nxt;
    logic             w_busy;
    logic             w_done;

    assign w_last   = (r_cnt == LAST_CNT);
    assign w_load   = (r_state != ST_COMPUTE) && bus.i_clr_ld;
    assign w_start  = (r_state == ST_IDLE) && bus.i_run && !bus.i_clr_ld;
    assign w_addend = r_mode ? {r_s[WIDTH-1], r_s} : {1'b0, r_s};
    assign w_acc    = {r_x, r_a};

    // The final signed iteration weights the multiplier MSB by -2^(WIDTH-1).
    always_comb begin
        w_sum = w_acc;
        if (r_b[0]) begin
            if (r_mode && w_last) w_sum = w_acc - w_addend;
            else                  w_sum = w_acc + w_addend;
        end
    end

    // In unsigned mode w_sum[WIDTH] is the carry, so one shift form serves both modes.
    assign w_a_nxt = w_sum[WIDTH:1];
    assign w_b_nxt = {w_sum[0], r_b[WIDTH-1:1]};
    assign w_x_nxt = r_mode & w_sum[WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE:    if (bus.i_clr_ld || !bus.i_run) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_COMPUTE);
        w_done = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_s    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_x    <= 1'b0;
            r_mode <= 1'b0;
        end else if (w_load) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= bus.i_din;
        end else if (w_start) begin
            r_s    <= bus.i_din;
            r_mode <= bus.i_signed_mode;
            r_a    <= '0;
            r_x    <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == ST_COMPUTE) begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_x   <= w_x_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef OVF_DETECT_EN
    logic r_ovf;
    logic w_ovf_nxt;

    assign w_ovf_nxt = r_mode ? (w_a_nxt != {WIDTH{w_b_nxt[WIDTH-1]}}) : (w_a_nxt != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                             r_ovf <= 1'b0;
        else if (w_load || w_start)               r_ovf <= 1'b0;
        else if (r_state == ST_COMPUTE && w_last) r_ovf <= w_ovf_nxt;
    end

    assign bus.o_overflow = r_ovf;
`endif

    assign bus.o_aval = r_a;
    assign bus.o_bval = r_b;
    assign bus.o_x    = r_x;
    assign bus.o_busy = w_busy;
    assign bus.o_done = w_done;
endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: transaction-level product model plus directed literal cases and random traffic.
module tb_seq_mult_param;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic cmp_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    seq_mult_param_if #(.WIDTH(W)) bus ();
    seq_mult_param #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic signed [63:0] ref_full(input logic [W-1:0] b, input logic [W-1:0] s, input logic sm);
        longint pb, ps;
        if (sm) begin
            pb = longint'($signed(b));
            ps = longint'($signed(s));
        end else begin
            pb = longint'({56'd0, b});
            ps = longint'({56'd0, s});
        end
        return pb * ps;
    endfunction

    function automatic logic ref_ovf(input logic signed [63:0] p, input logic sm);
        if (sm) return (p < -(64'sd1 <<< (W-1))) || (p > ((64'sd1 <<< (W-1)) - 64'sd1));
        else    return p >= (64'sd1 <<< W);
    endfunction

    // Model: 0 = idle, 1 = busy (W cycles), 2 = done
    int               m_phase = 0;
    int               m_left  = 0;
    logic [2*W-1:0]   m_prod  = '0;
    logic [2*W-1:0]   m_pend  = '0;
    logic             m_x     = 1'b0;
    logic             m_xp    = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             m_ovfp  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_prod <= '0; m_x <= 1'b0; m_ovf <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.i_clr_ld) begin
                        m_prod <= {{W{1'b0}}, bus.i_din}; m_x <= 1'b0; m_ovf <= 1'b0;
                    end else if (bus.i_run) begin
                        m_pend  <= (2*W)'(ref_full(m_prod[W-1:0], bus.i_din, bus.i_signed_mode));
                        m_xp    <= bus.i_signed_mode & ref_full(m_prod[W-1:0], bus.i_din, bus.i_signed_mode) < 0;
                        m_ovfp  <= ref_ovf(ref_full(m_prod[W-1:0], bus.i_din, bus.i_signed_mode), bus.i_signed_mode);
                        m_ovf   <= 1'b0;
                        m_phase <= 1;
                        m_left  <= W;
                    end
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2; m_prod <= m_pend; m_x <= m_xp; m_ovf <= m_ovfp;
                    end
                end
                default: begin
                    if (bus.i_clr_ld) begin
                        m_prod <= {{W{1'b0}}, bus.i_din}; m_x <= 1'b0; m_ovf <= 1'b0; m_phase <= 0;
                    end else if (!bus.i_run) begin
                        m_phase <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", bus.o_busy, m_phase == 1);
            check("done", bus.o_done, m_phase == 2);
            if (m_phase != 1) begin
                check("aval", bus.o_aval, m_prod[2*W-1:W]);
                check("bval", bus.o_bval, m_prod[W-1:0]);
                check("x", bus.o_x, m_x);
            end
`ifdef OVF_DETECT_EN
            check("overflow", bus.o_overflow, m_ovf);
`endif
        end
    end

    task automatic step(input logic run, input logic clr, input logic sm, input logic [W-1:0] din);
        @(posedge clk);
        #2;
        bus.i_run = run; bus.i_clr_ld = clr; bus.i_signed_mode = sm; bus.i_din = din;
    endtask

    task automatic wait_done(output int busy_cyc);
        bit seen;
        seen = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 4*W && !seen; i++) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
            else if (bus.o_busy) busy_cyc++;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic check_prod(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic x);
        check({name, "_aval"}, bus.o_aval, a);
        check({name, "_bval"}, bus.o_bval, b);
        check({name, "_x"}, bus.o_x, x);
    endtask

    task automatic check_zero(input string name);
        check({name, "_aval"}, bus.o_aval, 0);
        check({name, "_bval"}, bus.o_bval, 0);
        check({name, "_x"}, bus.o_x, 0);
        check({name, "_busy"}, bus.o_busy, 0);
        check({name, "_done"}, bus.o_done, 0);
    endtask

    initial begin
        int bc;
        logic [31:0] r;
        bus.i_run = 1'b0; bus.i_clr_ld = 1'b0; bus.i_signed_mode = 1'b0; bus.i_din = '0;
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // -59 * 7 = -413, Run held high through DONE
        step(0, 1, 0, 8'hC5);
        step(1, 0, 1, 8'h07);
        wait_done(bc);
        check("busy_cycles", bc, W);
        check_prod("neg413", 8'hFE, 8'h63, 1'b1);
        repeat (4) @(negedge clk);
        check("no_retrigger_busy", bus.o_busy, 0);
        check("held_done", bus.o_done, 1);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        @(negedge clk);
        check("idle_after_run_low", bus.o_done, 0);

        // back-to-back: previous low half 99 times 2
        step(1, 0, 1, 8'h02);
        step(0, 0, 0, 8'h00);
        wait_done(bc);
        check_prod("b2b198", 8'h00, 8'hC6, 1'b0);

        step(0, 1, 0, 8'hFF);
        step(1, 0, 0, 8'hFF);
        step(0, 0, 0, 8'h00);
        wait_done(bc);
        check_prod("u255sq", 8'hFE, 8'h01, 1'b0);
`ifdef OVF_DETECT_EN
        check("u255sq_ovf", bus.o_overflow, 1);
`endif

        step(0, 1, 0, 8'h80);
        step(1, 0, 1, 8'h80);
        step(0, 0, 0, 8'h00);
        wait_done(bc);
        check_prod("s128sq", 8'h40, 8'h00, 1'b0);

        step(0, 1, 0, 8'h03);
        step(1, 0, 1, 8'hFE);
        step(0, 0, 0, 8'h00);
        wait_done(bc);
        check_prod("s3xm2", 8'hFF, 8'hFA, 1'b1);
`ifdef OVF_DETECT_EN
        check("s3xm2_ovf", bus.o_overflow, 0);
`endif

        step(0, 1, 0, 8'h10);
        step(1, 0, 0, 8'h10);
        step(0, 0, 0, 8'h00);
        wait_done(bc);
        check_prod("u16sq", 8'h01, 8'h00, 1'b0);
`ifdef OVF_DETECT_EN
        check("u16sq_ovf", bus.o_overflow, 1);
`endif

        // Clr_Ld wins over Run in the same idle cycle
        step(1, 1, 1, 8'h33);
        step(0, 0, 0, 8'h00);
        @(negedge clk);
        check("clr_run_busy", bus.o_busy, 0);
        check("clr_run_bval", bus.o_bval, 8'h33);

        // asynchronous reset in the middle of a computation
        step(0, 1, 0, 8'h5A);
        step(1, 0, 1, 8'h3C);
        step(0, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            step((r[3:0] < 4'd5), (r[7:4] == 4'd0), r[8], W'($urandom));
        end
        step(0, 0, 0, 8'h00);
        repeat (W + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
